fix_admin_tx: RTL and testbench

Transmit-side companion to `session_manager` in the FIX engine. It turns the session manager's send requests (Heartbeat, Logon, Logout, ResendRequest) into complete, serialized FIX 4.2 administrative messages. Each message carries BodyLength and CheckSum fields and is emitted one byte per transfer on a valid/ready stream toward the network framer.

---
 rtl/fix_admin_tx.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fix_admin_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fix_admin_tx.sv
// FIX 4.2 administrative message transmitter: turns session-manager send requests into
// serialized Heartbeat/Logon/Logout/ResendRequest messages with BodyLength and CheckSum.
module fix_admin_tx #(
    parameter int SEQ_W       = 10,
    parameter int HEARTBT_INT = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sendHeartbeat_i,
    input  logic             sendLogon_i,
    input  logic             sendLogout_i,
    input  logic             resendReq_i,
    input  logic [SEQ_W-1:0] seq_num_i,
    input  logic [SEQ_W-1:0] resend_begin_i,
    input  logic             tx_ready_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    output logic             tx_sop_o,
    output logic             tx_eop_o,
    output logic             busy_o,
    output logic             msg_sent_o,
    output logic [1:0]       msg_type_o
);

    typedef enum logic [2:0] {IDLE, CONV, BODY, CKCONV, TRAILER, DONE} state_e;

    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] HB_D2 = 8'(48 + (HEARTBT_INT / 100) % 10);
    localparam logic [7:0] HB_D1 = 8'(48 + (HEARTBT_INT / 10) % 10);
    localparam logic [7:0] HB_D0 = 8'(48 + HEARTBT_INT % 10);

    state_e             state_q;
    logic [3:0]         pend_q, pend_d, pend_clr;
    logic               sel_valid;
    logic [1:0]         sel_type;
    logic [1:0]         msg_type_q;
    logic [SEQ_W-1:0]   seq_sh_q, beg_sh_q;
    logic [15:0]        seq_bcd_q, beg_bcd_q;
    logic [7:0]         ck_sh_q, csum_q;
    logic [11:0]        ck_bcd_q;
    logic [3:0]         cnt_q;
    logic [5:0]         idx_q, idx_nxt, body_last;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q, tx_sop_q, tx_eop_q, msg_sent_q;
    logic               accept;
    logic [7:0]         body_nxt_byte, trl_nxt_byte;

    function automatic logic [15:0] dd4(input logic [15:0] bcd, input logic in_bit);
        logic [15:0] a;
        a = bcd;
        for (int k = 0; k < 4; k++) begin
            if (a[4*k +: 4] >= 4'd5) a[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return {a[14:0], in_bit};
    endfunction

    function automatic logic [11:0] dd3(input logic [11:0] bcd, input logic in_bit);
        logic [11:0] a;
        a = bcd;
        for (int k = 0; k < 3; k++) begin
            if (a[4*k +: 4] >= 4'd5) a[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return {a[10:0], in_bit};
    endfunction

    // Header and body bytes laid out by absolute index from the leading '8'.
    function automatic logic [7:0] body_byte(input logic [5:0] i, input logic [1:0] t,
                                             input logic [15:0] s, input logic [15:0] b);
        logic [7:0] r;
        r = SOH;
        case (i)
            6'd0:  r = "8";
            6'd1:  r = "=";
            6'd2:  r = "F";
            6'd3:  r = "I";
            6'd4:  r = "X";
            6'd5:  r = ".";
            6'd6:  r = "4";
            6'd7:  r = ".";
            6'd8:  r = "2";
            6'd10: r = "9";
            6'd11: r = "=";
            6'd12: r = "0";
            6'd13: r = (t == 2'd1 || t == 2'd3) ? "2" : "1";
            6'd14: r = (t == 2'd1) ? "6" : ((t == 2'd3) ? "5" : "3");
            6'd16: r = "3";
            6'd17: r = "5";
            6'd18: r = "=";
            6'd19: r = (t == 2'd0) ? "0" : ((t == 2'd1) ? "A" : ((t == 2'd2) ? "5" : "2"));
            6'd21: r = "3";
            6'd22: r = "4";
            6'd23: r = "=";
            6'd24: r = {4'h3, s[15:12]};
            6'd25: r = {4'h3, s[11:8]};
            6'd26: r = {4'h3, s[7:4]};
            6'd27: r = {4'h3, s[3:0]};
            default: begin
                if (t == 2'd1) begin
                    case (i)
                        6'd29: r = "9";
                        6'd30: r = "8";
                        6'd31: r = "=";
                        6'd32: r = "0";
                        6'd34: r = "1";
                        6'd35: r = "0";
                        6'd36: r = "8";
                        6'd37: r = "=";
                        6'd38: r = HB_D2;
                        6'd39: r = HB_D1;
                        6'd40: r = HB_D0;
                        default: r = SOH;
                    endcase
                end else if (t == 2'd3) begin
                    case (i)
                        6'd29: r = "7";
                        6'd30: r = "=";
                        6'd31: r = {4'h3, b[15:12]};
                        6'd32: r = {4'h3, b[11:8]};
                        6'd33: r = {4'h3, b[7:4]};
                        6'd34: r = {4'h3, b[3:0]};
                        6'd36: r = "1";
                        6'd37: r = "6";
                        6'd38: r = "=";
                        6'd39: r = "0";
                        default: r = SOH;
                    endcase
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [7:0] trl_byte(input logic [2:0] i, input logic [11:0] c);
        logic [7:0] r;
        case (i)
            3'd0:    r = "1";
            3'd1:    r = "0";
            3'd2:    r = "=";
            3'd3:    r = {4'h3, c[11:8]};
            3'd4:    r = {4'h3, c[7:4]};
            3'd5:    r = {4'h3, c[3:0]};
            default: r = SOH;
        endcase
        return r;
    endfunction

    assign accept        = tx_valid_q && tx_ready_i;
    assign idx_nxt       = idx_q + 6'd1;
    assign body_last     = (msg_type_q == 2'd1) ? 6'd41 : ((msg_type_q == 2'd3) ? 6'd40 : 6'd28);
    assign body_nxt_byte = body_byte(idx_nxt, msg_type_q, seq_bcd_q, beg_bcd_q);
    assign trl_nxt_byte  = trl_byte(idx_nxt[2:0], ck_bcd_q);

    // Priority Logout > Logon > ResendRequest > Heartbeat; a new pulse beats the clear.
    always_comb begin
        sel_valid = (state_q == IDLE) && (pend_q != 4'd0);
        sel_type  = 2'd0;
        if (pend_q[2])      sel_type = 2'd2;
        else if (pend_q[1]) sel_type = 2'd1;
        else if (pend_q[3]) sel_type = 2'd3;
        pend_clr  = sel_valid ? 4'(4'b0001 << sel_type) : 4'd0;
        pend_d    = (pend_q & ~pend_clr) | {resendReq_i, sendLogout_i, sendLogon_i, sendHeartbeat_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 4'd0;
        else     pend_q <= pend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_type_q <= 2'd0;
            seq_sh_q   <= '0;
            beg_sh_q   <= '0;
            seq_bcd_q  <= 16'd0;
            beg_bcd_q  <= 16'd0;
            ck_sh_q    <= 8'd0;
            ck_bcd_q   <= 12'd0;
            csum_q     <= 8'd0;
            cnt_q      <= 4'd0;
            idx_q      <= 6'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            msg_sent_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q    <= CONV;
                        msg_type_q <= sel_type;
                        seq_sh_q   <= seq_num_i;
                        beg_sh_q   <= resend_begin_i;
                        seq_bcd_q  <= 16'd0;
                        beg_bcd_q  <= 16'd0;
                        csum_q     <= 8'd0;
                        cnt_q      <= 4'd0;
                    end
                end
                CONV: begin
                    seq_bcd_q <= dd4(seq_bcd_q, seq_sh_q[SEQ_W-1]);
                    beg_bcd_q <= dd4(beg_bcd_q, beg_sh_q[SEQ_W-1]);
                    seq_sh_q  <= seq_sh_q << 1;
                    beg_sh_q  <= beg_sh_q << 1;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'(SEQ_W - 1)) begin
                        state_q    <= BODY;
                        idx_q      <= 6'd0;
                        tx_data_q  <= "8";
                        tx_valid_q <= 1'b1;
                        tx_sop_q   <= 1'b1;
                    end
                end
                BODY: begin
                    if (accept) begin
                        csum_q   <= csum_q + tx_data_q;
                        tx_sop_q <= 1'b0;
                        if (idx_q == body_last) begin
                            state_q    <= CKCONV;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'd0;
                            cnt_q      <= 4'd0;
                            ck_sh_q    <= csum_q + tx_data_q;
                            ck_bcd_q   <= 12'd0;
                        end else begin
                            idx_q     <= idx_nxt;
                            tx_data_q <= body_nxt_byte;
                        end
                    end
                end
                CKCONV: begin
                    ck_bcd_q <= dd3(ck_bcd_q, ck_sh_q[7]);
                    ck_sh_q  <= ck_sh_q << 1;
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_q    <= TRAILER;
                        idx_q      <= 6'd0;
                        tx_data_q  <= "1";
                        tx_valid_q <= 1'b1;
                    end
                end
                TRAILER: begin
                    if (accept) begin
                        if (idx_q == 6'd6) begin
                            state_q    <= DONE;
                            tx_valid_q <= 1'b0;
                            tx_eop_q   <= 1'b0;
                            tx_data_q  <= 8'd0;
                            msg_sent_q <= 1'b1;
                        end else begin
                            idx_q     <= idx_nxt;
                            tx_data_q <= trl_nxt_byte;
                            tx_eop_q  <= (idx_nxt == 6'd6);
                        end
                    end
                end
                DONE: begin
                    msg_sent_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_sop_o   = tx_sop_q;
    assign tx_eop_o   = tx_eop_q;
    assign busy_o     = (state_q != IDLE);
    assign msg_sent_o = msg_sent_q;
    assign msg_type_o = msg_type_q;

endmodule

// File: tb/tb_fix_admin_tx.sv
// Self-checking bench for fix_admin_tx: expected messages are composed as FIX text from
// field rules and compared byte by byte, with random backpressure and random field values.
module tb_fix_admin_tx;

    localparam int SEQ_W  = 10;
    localparam int HB_INT = 30;

    logic             clk = 1'b0;
    logic             rst;
    logic             sendHeartbeat_i, sendLogon_i, sendLogout_i, resendReq_i;
    logic [SEQ_W-1:0] seq_num_i, resend_begin_i;
    logic             tx_ready_i;
    logic [7:0]       tx_data_o;
    logic             tx_valid_o, tx_sop_o, tx_eop_o, busy_o, msg_sent_o;
    logic [1:0]       msg_type_o;

    int nAsserts = 0;
    int nFails   = 0;

    fix_admin_tx #(.SEQ_W(SEQ_W), .HEARTBT_INT(HB_INT)) dut (
        .clk(clk), .rst(rst),
        .sendHeartbeat_i(sendHeartbeat_i), .sendLogon_i(sendLogon_i),
        .sendLogout_i(sendLogout_i), .resendReq_i(resendReq_i),
        .seq_num_i(seq_num_i), .resend_begin_i(resend_begin_i),
        .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .busy_o(busy_o),
        .msg_sent_o(msg_sent_o), .msg_type_o(msg_type_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference message built as text from the FIX field rules.
    function automatic string buildMsg(input int t, input int seq, input int beg);
        string soh, tc, body, head;
        int sum;
        soh  = $sformatf("%c", 8'd1);
        tc   = (t == 0) ? "0" : (t == 1) ? "A" : (t == 2) ? "5" : "2";
        body = {"35=", tc, soh, $sformatf("34=%04d", seq), soh};
        if (t == 1) body = {body, "98=0", soh, $sformatf("108=%03d", HB_INT), soh};
        if (t == 3) body = {body, $sformatf("7=%04d", beg), soh, "16=0", soh};
        head = {"8=FIX.4.2", soh, $sformatf("9=%03d", body.len()), soh};
        sum  = 0;
        for (int i = 0; i < head.len(); i++) sum += head[i];
        for (int i = 0; i < body.len(); i++) sum += body[i];
        return {head, body, $sformatf("10=%03d", sum % 256), soh};
    endfunction

    task automatic applyStimulus(input logic [3:0] req, input int seq, input int beg);
        @(posedge clk); #1;
        tx_ready_i      = 1'b1;
        sendHeartbeat_i = req[0];
        sendLogon_i     = req[1];
        sendLogout_i    = req[2];
        resendReq_i     = req[3];
        seq_num_i       = SEQ_W'(seq);
        resend_begin_i  = SEQ_W'(beg);
        @(posedge clk); #1;
        {resendReq_i, sendLogout_i, sendLogon_i, sendHeartbeat_i} = 4'd0;
    endtask

    // Collects one message; may drop early (abortAfter) or pulse a heartbeat mid-stream.
    task automatic receiveMessage(input string tag, input string expMsg, input logic [1:0] expType,
                                  input int readyPct, input int abortAfter, input int hbPulseAt,
                                  output int busyCycles, output int nBytes);
        int   idx = 0;
        int   cyc = 0;
        bit   done = 0, sent = 0, prevStall = 0, pulsed = 0;
        logic [7:0] prevData = 8'd0;
        busyCycles = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            if (busy_o) busyCycles++;
            if (prevStall) begin
                checkOutput({tag, "_holdValid"}, 32'(tx_valid_o), 32'd1);
                checkOutput({tag, "_holdData"}, 32'(tx_data_o), 32'(prevData));
            end
            prevStall = 0;
            if (tx_valid_o) begin
                if (tx_ready_i) begin
                    if (idx < expMsg.len()) begin
                        checkOutput($sformatf("%s_byte%0d", tag, idx), 32'(tx_data_o), 32'(expMsg[idx]));
                        checkOutput($sformatf("%s_sop%0d", tag, idx), 32'(tx_sop_o), 32'(idx == 0));
                        checkOutput($sformatf("%s_eop%0d", tag, idx), 32'(tx_eop_o), 32'(idx == expMsg.len() - 1));
                    end else begin
                        checkOutput({tag, "_extraByte"}, 32'(idx), 32'(expMsg.len()));
                    end
                    idx++;
                end else begin
                    prevStall = 1;
                    prevData  = tx_data_o;
                end
            end
            if (msg_sent_o) begin
                sent = 1;
                done = 1;
                checkOutput({tag, "_msgType"}, 32'(msg_type_o), 32'(expType));
            end else begin
                @(posedge clk); #1;
                tx_ready_i      = (readyPct >= 100) ? 1'b1 : ($urandom_range(99) < readyPct);
                sendHeartbeat_i = 1'b0;
                if (!pulsed && hbPulseAt >= 0 && idx >= hbPulseAt) begin
                    sendHeartbeat_i = 1'b1;
                    pulsed = 1;
                end
                if (abortAfter >= 0 && idx == abortAfter) done = 1;
                cyc++;
            end
        end
        nBytes = idx;
        if (abortAfter < 0) begin
            checkOutput({tag, "_sent"}, 32'(sent), 32'd1);
            checkOutput({tag, "_byteCount"}, 32'(idx), 32'(expMsg.len()));
        end else begin
            checkOutput({tag, "_reachedAbort"}, 32'(idx), 32'(abortAfter));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc, nb, cnt, t, s, b;
        string m;
        rst = 1'b1;
        tx_ready_i = 1'b1;
        {resendReq_i, sendLogout_i, sendLogon_i, sendHeartbeat_i} = 4'd0;
        seq_num_i = '0;
        resend_begin_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(tx_valid_o), 32'd0);
        checkOutput("rst_data", 32'(tx_data_o), 32'd0);
        checkOutput("rst_sop", 32'(tx_sop_o), 32'd0);
        checkOutput("rst_eop", 32'(tx_eop_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_sent", 32'(msg_sent_o), 32'd0);
        checkOutput("rst_type", 32'(msg_type_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Heartbeat reference case, including the known checksum and latency.
        applyStimulus(4'b0001, 5, 0);
        m = buildMsg(0, 5, 0);
        receiveMessage("hb", m, 2'd0, 100, -1, -1, bc, nb);
        checkOutput("hb_len36", 32'(nb), 32'd36);
        checkOutput("hb_busyCycles", 32'(bc), 32'd55);
        @(negedge clk);
        checkOutput("hb_sentPulseEnds", 32'(msg_sent_o), 32'd0);
        checkOutput("hb_ckDigit0", 32'(m[32]), 32'("1"));
        checkOutput("hb_ckDigit2", 32'(m[34]), 32'("6"));

        applyStimulus(4'b0010, 1, 0);
        receiveMessage("logon", buildMsg(1, 1, 0), 2'd1, 100, -1, -1, bc, nb);
        checkOutput("logon_len49", 32'(nb), 32'd49);

        applyStimulus(4'b1000, 0, 1023);
        receiveMessage("resend", buildMsg(3, 0, 1023), 2'd3, 100, -1, -1, bc, nb);
        applyStimulus(4'b1000, 0, 1023);
        receiveMessage("resendStall", buildMsg(3, 0, 1023), 2'd3, 50, -1, -1, bc, nb);

        for (int k = 0; k < 6; k++) begin
            t = int'($urandom_range(3));
            s = int'($urandom_range((1 << SEQ_W) - 1));
            b = int'($urandom_range((1 << SEQ_W) - 1));
            applyStimulus(4'(1 << t), s, b);
            receiveMessage($sformatf("rand%0d", k), buildMsg(t, s, b), 2'(t), 60, -1, -1, bc, nb);
        end

        // Logout wins over a simultaneous heartbeat; a repeat heartbeat coalesces.
        applyStimulus(4'b0101, 42, 0);
        receiveMessage("prioLogout", buildMsg(2, 42, 0), 2'd2, 100, -1, 10, bc, nb);
        receiveMessage("prioHb", buildMsg(0, 42, 0), 2'd0, 100, -1, -1, bc, nb);
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (tx_valid_o || busy_o) cnt++;
        end
        checkOutput("prio_noExtraMsg", 32'(cnt), 32'd0);

        // Reset in the middle of a Logon.
        applyStimulus(4'b0010, 9, 0);
        receiveMessage("abortLogon", buildMsg(1, 9, 0), 2'd1, 100, 20, -1, bc, nb);
        rst = 1'b1;
        #1;
        checkOutput("midRst_valid", 32'(tx_valid_o), 32'd0);
        checkOutput("midRst_data", 32'(tx_data_o), 32'd0);
        checkOutput("midRst_eop", 32'(tx_eop_o), 32'd0);
        checkOutput("midRst_busy", 32'(busy_o), 32'd0);
        checkOutput("midRst_type", 32'(msg_type_o), 32'd0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (msg_sent_o || tx_eop_o || tx_valid_o) cnt++;
        end
        checkOutput("midRst_quiet", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(4'b0001, 77, 0);
        receiveMessage("postRstHb", buildMsg(0, 77, 0), 2'd0, 100, -1, -1, bc, nb);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
